// File: rtl/accel_msg_replicator.sv
// Thread-range multicast stage for an accelerator's outgoing message stream.
// One accepted message becomes N copies sent to consecutive thread addresses,
// starting at the message's own destination. The copy count comes from payload
// word 1. Idle-detection tokens go through exactly once, unmodified.

package accel_msg_pkg;

    // Mailbox geometry. The range field R is {core_id, thread_id}.
    localparam int LOG_CORES_PER_MAILBOX = 4;
    localparam int LOG_THREADS_PER_CORE  = 4;
    localparam int RANGE_W               = LOG_CORES_PER_MAILBOX + LOG_THREADS_PER_CORE;

    localparam int PAYLOAD_W      = 128;
    // The copy count is the low byte of payload word 1, at bits [39:32].
    localparam int COPY_COUNT_LSB = 32;

    typedef struct packed {
        logic                             acc;
        logic                             host;
        logic [2:0]                       board_y;
        logic [2:0]                       board_x;
        logic [1:0]                       tile_y;
        logic [1:0]                       tile_x;
        logic [LOG_CORES_PER_MAILBOX-1:0] core_id;
        logic [LOG_THREADS_PER_CORE-1:0]  thread_id;
    } net_addr_t;

    typedef struct packed {
        net_addr_t              dest;
        logic [1:0]             num_words;
        logic                   is_idle_token;
        logic [PAYLOAD_W-1:0]   payload;
    } msg_t;

    localparam int MSG_W = $bits(msg_t);

endpackage

module accel_msg_replicator
    import accel_msg_pkg::*;
#(
    parameter int MAX_FANOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MSG_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [MSG_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [31:0]      sent_count
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // MAX_FANOUT may be as large as 256, so the count needs 9 bits.
    localparam logic [8:0] MAX_N = 9'(MAX_FANOUT);

    state_t              state_reg, state_next;
    msg_t                msg_reg, msg_next;
    logic [8:0]          n_reg, n_next;
    logic [8:0]          idx_reg, idx_next;
    logic [31:0]         sent_count_reg;

    msg_t                in_msg;
    msg_t                out_msg;
    logic                last_copy;
    logic                in_xfer;
    logic                out_xfer;
    logic [RANGE_W-1:0]  range_base;
    logic [RANGE_W-1:0]  range_copy;

    assign in_msg = msg_t'(in_data);

    // Number of copies for a message: idle tokens and a zero count give one
    // copy, and larger counts are clamped to MAX_FANOUT.
    function automatic logic [8:0] copy_count(input msg_t m);
        logic [8:0] c;
        logic [8:0] n;
        c = {1'b0, m.payload[COPY_COUNT_LSB +: 8]};
        if (m.is_idle_token || (c == 9'd0)) begin
            n = 9'd1;
        end else if (c > MAX_N) begin
            n = MAX_N;
        end else begin
            n = c;
        end
        return n;
    endfunction

    // The range add is only RANGE_W bits wide, so a wrap never carries into
    // the tile, board, host or acc fields.
    assign range_base = {msg_reg.dest.core_id, msg_reg.dest.thread_id};
    assign range_copy = range_base + RANGE_W'(idx_reg);
    assign last_copy  = (idx_reg == (n_reg - 9'd1));

    // Copy idx of the latched message; built only from registers, so it stays
    // stable for as long as the downstream stalls.
    always_comb begin
        out_msg = msg_reg;
        {out_msg.dest.core_id, out_msg.dest.thread_id} = range_copy;
    end

    assign out_data   = MSG_W'(out_msg);
    assign busy       = (state_reg == ST_SEND);
    assign sent_count = sent_count_reg;

    // Next-state and handshake logic. On the last copy, in_ready follows
    // out_ready combinationally so a new message can be taken without a bubble.
    always_comb begin
        state_next = state_reg;
        msg_next   = msg_reg;
        n_next     = n_reg;
        idx_next   = idx_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        in_xfer    = 1'b0;
        out_xfer   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                in_xfer  = in_valid;
                if (in_xfer) begin
                    msg_next   = in_msg;
                    n_next     = copy_count(in_msg);
                    idx_next   = 9'd0;
                    state_next = ST_SEND;
                end
            end

            ST_SEND: begin
                out_valid = 1'b1;
                in_ready  = last_copy && out_ready;
                out_xfer  = out_ready;
                in_xfer   = in_valid && in_ready;
                if (out_xfer) begin
                    if (!last_copy) begin
                        idx_next = idx_reg + 9'd1;
                    end else if (in_xfer) begin
                        msg_next = in_msg;
                        n_next   = copy_count(in_msg);
                        idx_next = 9'd0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; this pipeline updates on the falling clock edge.
    // Reset abandons any copies still outstanding.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            msg_reg        <= '0;
            n_reg          <= 9'd1;
            idx_reg        <= 9'd0;
            sent_count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            msg_reg   <= msg_next;
            n_reg     <= n_next;
            idx_reg   <= idx_next;
            if (out_xfer) begin
                sent_count_reg <= sent_count_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_accel_msg_replicator.sv
// Directed bench for accel_msg_replicator: reset, single copy, range wrap,
// clamp under random backpressure, back-to-back messages, idle token and
// reset in the middle of a burst.

module tb_accel_msg_replicator;
    import accel_msg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [31:0] sent_count;
    msg_t        in_data;
    msg_t        out_data;

    int errors = 0;
    int checks = 0;

    // Clock: DUT updates on the falling edge, bench samples/drives just after the rising edge.
    always #5 clk = ~clk;

    accel_msg_replicator #(
        .MAX_FANOUT(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .sent_count (sent_count)
    );

    // Simulation watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_msg(input string tag, input msg_t obs, input msg_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic msg_t mk(input logic [1:0] tx, input logic [1:0] ty,
                                input logic [7:0] r, input logic [7:0] c,
                                input logic idle);
        msg_t m;
        m.dest.acc       = 1'b0;
        m.dest.host      = 1'b1;
        m.dest.board_y   = 3'd5;
        m.dest.board_x   = 3'd3;
        m.dest.tile_y    = ty;
        m.dest.tile_x    = tx;
        m.dest.core_id   = r[7:4];
        m.dest.thread_id = r[3:0];
        m.num_words      = 2'd2;
        m.is_idle_token  = idle;
        m.payload        = 128'hA5A5_5A5A_1234_5678_9ABC_DEF0_0000_00C3;
        m.payload[39:32] = c;
        return m;
    endfunction

    function automatic msg_t with_r(input msg_t m, input logic [7:0] r);
        msg_t x;
        x = m;
        x.dest.core_id   = r[7:4];
        x.dest.thread_id = r[3:0];
        return x;
    endfunction

    initial begin
        msg_t        a_msg;
        msg_t        held;
        logic        stalled;
        int          got;
        int          cyc;
        logic [7:0]  wrap_r [4];
        logic [7:0]  b2b_r [5];
        logic [7:0]  rst_r [3];

        wrap_r = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        b2b_r  = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31};
        rst_r  = '{8'h50, 8'h51, 8'h52};

        // ---- Reset held 3 falling edges with in_valid high ----
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = mk(2'd1, 2'd1, 8'h77, 8'd5, 1'b0);
        repeat (4) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sent_count", sent_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        chk("rst_nothing_latched", 32'(out_valid), 32'd0);

        // ---- Single copy, c=0, R=0x05 ----
        a_msg    = mk(2'd1, 2'd2, 8'h05, 8'd0, 1'b0);
        in_data  = a_msg;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        chk_msg("single_data", out_data, a_msg);
        step();
        chk("single_done_valid", 32'(out_valid), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);
        chk("single_sent_count", sent_count, 32'd1);

        // ---- Range wrap: R=0xFE, c=4 ----
        a_msg    = mk(2'd3, 2'd1, 8'hFE, 8'd4, 1'b0);
        in_data  = a_msg;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_valid", 32'(out_valid), 32'd1);
            chk_msg("wrap_copy", out_data, with_r(a_msg, wrap_r[i]));
            chk("wrap_tile_x", 32'(out_data.dest.tile_x), 32'd3);
            chk("wrap_tile_y", 32'(out_data.dest.tile_y), 32'd1);
            step();
        end
        chk("wrap_done_valid", 32'(out_valid), 32'd0);
        chk("wrap_sent_count", sent_count, 32'd5);

        // ---- Clamp c=200 -> 64 copies under random backpressure ----
        a_msg     = mk(2'd0, 2'd3, 8'h10, 8'd200, 1'b0);
        in_data   = a_msg;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("clamp_in_ready_blocked", 32'(in_ready), 32'd0);
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (got < 64 && cyc < 2000) begin
            chk("clamp_valid", 32'(out_valid), 32'd1);
            if (stalled) chk_msg("clamp_stable", out_data, held);
            chk_msg("clamp_copy", out_data, with_r(a_msg, 8'(8'h10 + got)));
            out_ready = 1'($urandom_range(0, 1));
            if (out_ready) got++;
            stalled = !out_ready;
            held    = out_data;
            step();
            cyc++;
        end
        chk("clamp_copies", 32'(got), 32'd64);
        chk("clamp_done_valid", 32'(out_valid), 32'd0);
        chk("clamp_sent_count", sent_count, 32'd69);

        // ---- Back-to-back: c=3 then c=2, no bubble ----
        out_ready = 1'b1;
        a_msg     = mk(2'd2, 2'd0, 8'h20, 8'd3, 1'b0);
        in_data   = a_msg;
        in_valid  = 1'b1;
        step();
        in_data = mk(2'd2, 2'd0, 8'h30, 8'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk_msg("b2b_copy", out_data, with_r(i < 3 ? a_msg : in_data, b2b_r[i]));
            if (i < 2) chk("b2b_in_ready_low", 32'(in_ready), 32'd0);
            if (i == 2) chk("b2b_in_ready_last", 32'(in_ready), 32'd1);
            step();
            if (i == 2) in_valid = 1'b0;
        end
        chk("b2b_done_valid", 32'(out_valid), 32'd0);
        chk("b2b_sent_count", sent_count, 32'd74);

        // ---- Idle token with c=10: exactly one unmodified copy ----
        a_msg    = mk(2'd1, 2'd1, 8'h40, 8'd10, 1'b1);
        in_data  = a_msg;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("idle_valid", 32'(out_valid), 32'd1);
        chk_msg("idle_data", out_data, a_msg);
        step();
        chk("idle_done_valid", 32'(out_valid), 32'd0);
        chk("idle_sent_count", sent_count, 32'd75);

        // ---- Reset after copy 2 of 8 ----
        a_msg    = mk(2'd0, 2'd1, 8'h50, 8'd8, 1'b0);
        in_data  = a_msg;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_msg("midrst_copy", out_data, with_r(a_msg, rst_r[i]));
            step();
        end
        chk("midrst_pre_count", sent_count, 32'd78);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sent_count", sent_count, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_more", 32'(out_valid), 32'd0);
        end
        chk("midrst_count_after", sent_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
